// File: rtl/arbitro_rr8.sv
// Eight-way round-robin arbiter with registered one-hot grant and optional
// maximum-hold preemption (MAXHOLD = 0 lets an owner keep the grant forever).
module arbitro_rr8 #(
  parameter int unsigned MAXHOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] MAX_HOLD = 8'(MAXHOLD);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] next_ptr;
  logic [7:0] others;

  // First set bit of r scanning p, p+1, ... p+7 with 3-bit wraparound.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] sel;
    logic [2:0] cand;
    logic       found;
    sel   = p;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = p + 3'(i);
      if (!found && r[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    hcnt_d   = hcnt_q;
    next_ptr = idx_q + 3'd1;
    others   = req & ~(8'd1 << idx_q);
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = pick(req, ptr_q);
          hcnt_d  = 8'd1;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          ptr_d = next_ptr;
          if (|req) begin
            idx_d  = pick(req, next_ptr);
            hcnt_d = 8'd1;
          end else begin
            state_d = IDLE;
            idx_d   = 3'd0;
            hcnt_d  = 8'd0;
          end
        end else if ((MAX_HOLD != 8'd0) && (hcnt_q == MAX_HOLD) && (|others)) begin
          // The owner is last in the scan from next_ptr, so it cannot win again.
          ptr_d  = next_ptr;
          idx_d  = pick(others, next_ptr);
          hcnt_d = 8'd1;
        end else if (hcnt_q != 8'hFF) begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
    endcase
    gnt_d = (state_d == GRANT) ? (8'd1 << idx_d) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
      hcnt_q  <= 8'd0;
      gnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hcnt_q  <= hcnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == GRANT);

endmodule

// File: tb/tb_arbitro_rr8.sv
// Scoreboard bench for arbitro_rr8: three instances (MAXHOLD 16, 4, 0) share
// one stimulus stream and are each compared against a behavioural model.
module tb_arbitro_rr8;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt_w [3];
  logic [2:0] idx_w [3];
  logic       val_w [3];

  int checks = 0;
  int errors = 0;

  exp_t sb [3][$];
  int   m_owner [3];
  int   m_ptr   [3];
  int   m_held  [3];
  int   m_max   [3] = '{16, 4, 0};

  arbitro_rr8 #(.MAXHOLD(16)) dut_h16 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_w[0]), .gnt_idx(idx_w[0]), .gnt_valid(val_w[0])
  );
  arbitro_rr8 #(.MAXHOLD(4)) dut_h4 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_w[1]), .gnt_idx(idx_w[1]), .gnt_valid(val_w[1])
  );
  arbitro_rr8 #(.MAXHOLD(0)) dut_h0 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_w[2]), .gnt_idx(idx_w[2]), .gnt_valid(val_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin rule: first requester found walking up from p, modulo 8.
  function automatic int winner(input logic [7:0] r, input int p);
    for (int i = 0; i < 8; i++)
      if (r[(p + i) % 8]) return (p + i) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] bit_of(input int n);
    logic [7:0] v;
    v = 8'h00;
    v[n] = 1'b1;
    return v;
  endfunction

  // Advances one model by one clock edge and queues the response it predicts.
  task automatic model_step(input int d, input logic [7:0] r, input logic rs);
    exp_t e;
    if (rs) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
      m_held[d]  = 0;
    end else if (m_owner[d] < 0) begin
      if (r != 8'h00) begin
        m_owner[d] = winner(r, m_ptr[d]);
        m_held[d]  = 1;
      end
    end else if (!r[m_owner[d]]) begin
      m_ptr[d] = (m_owner[d] + 1) % 8;
      m_owner[d] = winner(r, m_ptr[d]);
      m_held[d]  = (m_owner[d] < 0) ? 0 : 1;
    end else if (m_max[d] != 0 && m_held[d] == m_max[d] &&
                 (r & ~bit_of(m_owner[d])) != 8'h00) begin
      m_ptr[d]   = (m_owner[d] + 1) % 8;
      m_owner[d] = winner(r & ~bit_of(m_owner[d]), m_ptr[d]);
      m_held[d]  = 1;
    end else begin
      m_held[d] = (m_held[d] >= 255) ? 255 : m_held[d] + 1;
    end
    e.valid = (m_owner[d] >= 0);
    e.gnt   = e.valid ? bit_of(m_owner[d]) : 8'h00;
    e.idx   = e.valid ? 3'(m_owner[d]) : 3'd0;
    sb[d].push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic rs);
    @(negedge clk);
    req = r;
    rst = rs;
    for (int d = 0; d < 3; d++) model_step(d, r, rs);
  endtask

  task automatic checkOutput(input string name, input int d, input logic [7:0] exp_gnt);
    @(posedge clk);
    #2;
    checks++;
    if (gnt_w[d] !== exp_gnt) begin
      errors++;
      $display("[TB] FAIL %s (dut %0d): gnt=%h expected %h", name, d, gnt_w[d], exp_gnt);
    end
  endtask

  // Monitor: every edge produces a new registered response; compare it to the oldest prediction.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 3; d++) begin
      if (sb[d].size() > 0) begin
        exp_t e;
        e = sb[d].pop_front();
        checks++;
        if (gnt_w[d] !== e.gnt || idx_w[d] !== e.idx || val_w[d] !== e.valid) begin
          errors++;
          $display("[TB] FAIL scoreboard dut %0d at %0t: gnt=%h idx=%0d valid=%b expected gnt=%h idx=%0d valid=%b",
                   d, $time, gnt_w[d], idx_w[d], val_w[d], e.gnt, e.idx, e.valid);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] r;
    logic       rs;
    rst = 1'b1;
    req = 8'h00;

    // Reset with all requests asserted, then first grant goes to requester 0.
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    checkOutput("reset_gnt", 0, 8'h00);
    checks++;
    if (idx_w[0] !== 3'd0 || val_w[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idx_valid: idx=%0d valid=%b expected 0 0", idx_w[0], val_w[0]);
    end
    applyStimulus(8'hFF, 1'b0);
    checkOutput("first_grant", 0, 8'h01);

    // Single requester 5 held for 5 cycles, then the next sweep starts at 6.
    applyStimulus(8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h20, 1'b0);
      checkOutput("single_hold", 0, 8'h20);
    end
    applyStimulus(8'h00, 1'b0);
    checkOutput("single_release", 0, 8'h00);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("ptr_after_single", 0, 8'h40);

    // Handoff 0 -> 7 with no bubble, then wrap 7 -> 0.
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0);
    checkOutput("handoff_owner0", 0, 8'h01);
    applyStimulus(8'h81, 1'b0);
    checkOutput("handoff_keep0", 0, 8'h01);
    applyStimulus(8'h80, 1'b0);
    checkOutput("handoff_to7", 0, 8'h80);
    applyStimulus(8'h01, 1'b0);
    checkOutput("handoff_wrap", 0, 8'h01);

    // MAXHOLD 4 with everyone requesting: each owner gets exactly 4 cycles.
    applyStimulus(8'h00, 1'b1);
    for (int c = 0; c < 36; c++) begin
      applyStimulus(8'hFF, 1'b0);
      checkOutput("preempt_rotation", 1, bit_of((c / 4) % 8));
    end

    // MAXHOLD 0 never preempts.
    applyStimulus(8'h00, 1'b1);
    for (int c = 0; c < 50; c++) begin
      applyStimulus(8'h0C, 1'b0);
      checkOutput("no_preempt", 2, 8'h04);
    end

    // Reset in the middle of a grant restores the pointer to 0.
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h08, 1'b0);
    checkOutput("mid_owner3", 0, 8'h08);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("mid_keep3", 0, 8'h08);
    applyStimulus(8'hFF, 1'b1);
    checkOutput("mid_reset", 0, 8'h00);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("mid_after_reset", 0, 8'h01);

    // Random traffic: requests persist and toggle occasionally, rare resets.
    r = 8'h00;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      rs = ($urandom_range(0, 99) == 0);
      applyStimulus(r, rs);
    end
    applyStimulus(8'h00, 1'b0);

    repeat (3) @(posedge clk);
    #3;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (sb[d].size() != 0) begin
        errors++;
        $display("[TB] FAIL drain dut %0d: %0d predictions left, expected 0", d, sb[d].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_rr8.md
# arbitro_rr8

Round-robin arbiter that shares one resource among eight requesters and drives a one-hot grant, the registered equivalent of a 3-to-8 decoder output selected by a rotating pointer. A requester keeps its grant while it holds its request, subject to an optional maximum-hold limit. Priority then rotates to the next requester index. The block sits between the requesting units and the shared resource's select logic; `gnt_idx` can drive a decoder or mux directly.

## Interface
- `MAXHOLD`, default 16: maximum consecutive cycles one grant is held while another requester waits. Range 0..255; 0 disables preemption.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  8  request lines; `req[i]` is requester i.
- `gnt`  out  8  one-hot grant; all zero when nothing is granted.
- `gnt_idx`  out  3  index of the granted requester; 0 when idle.
- `gnt_valid`  out  1  high while a grant is active.

## Operation
- State: FSM {IDLE, GRANT}, 3-bit priority pointer `ptr`, 3-bit `gnt_idx`, 8-bit hold counter `hcnt`.
- `gnt` = one-hot decode of `gnt_idx` when `gnt_valid` = 1, else 8'h00. At most one bit is ever set.
- Winner search: the first i with `req[i]` = 1, scanning `ptr`, `ptr+1`, … `ptr+7` (mod 8).
- IDLE: if `req` ≠ 0, grant the winner, enter GRANT, set `hcnt` = 1. Otherwise stay.
- GRANT, owner `k` = `gnt_idx`:
  - Release: `req[k]` = 0. Set `ptr` = k+1 mod 8. If any other request is pending, grant the new winner at the same edge (no idle bubble) and set `hcnt` = 1. Otherwise go to IDLE with `gnt_valid` = 0 and `gnt_idx` = 0.
  - Preempt: `MAXHOLD` ≠ 0, `hcnt` = `MAXHOLD`, `req[k]` = 1, and some `req[j]` = 1 with j ≠ k. Set `ptr` = k+1 mod 8 and grant the winner from that pointer, which is never k. Set `hcnt` = 1.
  - Otherwise keep the grant and set `hcnt` = min(`hcnt`+1, 255).
- If `hcnt` = `MAXHOLD` and no other request is pending, the owner keeps the grant. `hcnt` saturates. Preemption happens on the first edge at which any other request appears.
- `ptr` changes only on release or preemption. Reaching IDLE via release already advanced it. Wrap: 7+1 → 0.
- Requests are level-sensitive and sampled every edge. A request that drops before it is granted is simply lost; nothing is queued.

## Timing
- Reset (`rst` = 1 at an edge): `gnt` = 0, `gnt_idx` = 0, `gnt_valid` = 0, `ptr` = 0, `hcnt` = 0, state IDLE. This applies also mid-grant; `rst` overrides all other inputs.
- Grant latency: 1 cycle. A `req` set before edge n gives `gnt` visible after edge n.
- Release latency: 1 cycle. `req[k]` dropping before edge n gives `gnt[k]` = 0 after edge n, with the next owner's bit set after that same edge if one is pending.
- Preemption: a contended owner sees exactly `MAXHOLD` cycles of grant.
- Outputs are fully registered; there is no combinational path from `req` to `gnt`.
- Simultaneous release and new requests: the new requests take part in the same-edge search.

## Test plan
- Reset: hold `rst` 2 cycles with `req` = 8'hFF. Then `gnt` = 0, `gnt_valid` = 0, `gnt_idx` = 0. First grant after release is `gnt` = 8'h01.
- Single requester: `req` = 8'h20 for 5 cycles, then 0. `gnt` = 8'h20 from the first edge for 5 cycles, then 8'h00. The next grant from `req` = 8'hFF is 8'h40 (`ptr` = 6).
- Handoff: `req` = 8'h81, owner 0. Drop bit 0. The next edge gives `gnt` = 8'h80 with no zero cycle. Drop bit 7 and set bit 0: next grant 8'h01 (pointer wrap 7 → 0).
- Preemption, `MAXHOLD` = 4, `req` = 8'hFF held constantly: grants 8'h01, 8'h02, … 8'h80, 8'h01, each exactly 4 cycles.
- `MAXHOLD` = 0, `req` = 8'h0C held 50 cycles: `gnt` = 8'h04 for all 50 cycles.
- Reset mid-grant: owner 3 with `req` = 8'hFF, assert `rst` one cycle. Then `gnt` = 0. After release the next grant is 8'h01, not 8'h10.
